conv_window_reader: RTL and testbench



---
 rtl/conv_window_reader_if.sv | 44 ++++
 rtl/conv_window_reader.sv | 135 +++++++++++++
 tb/tb_conv_window_reader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_reader_if.sv
// conv_window_reader_if: buffer read bus and window handshake
// bundle between a double buffer, the reader and a conv core.
interface conv_window_reader_if #(
   parameter int WIDTH        = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int OUT_PORT_NUM = 25
);
   logic [1:0]                         data_fill_cnt;
   logic                               rd_en;
   logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP;
   logic [OUT_PORT_NUM*WIDTH-1:0]      rd_data_NP;
   logic [OUT_PORT_NUM*WIDTH-1:0]      win_data;
   logic                               win_valid;
   logic                               win_ready;
   logic [ADDR_WIDTH-1:0]              win_row;
   logic [ADDR_WIDTH-1:0]              win_col;
   logic                               frame_done;

   modport master (
      input  data_fill_cnt,
      input  rd_data_NP,
      input  win_ready,
      output rd_en,
      output rd_addr_NP,
      output win_data,
      output win_valid,
      output win_row,
      output win_col,
      output frame_done
   );

   modport slave (
      output data_fill_cnt,
      output rd_data_NP,
      output win_ready,
      input  rd_en,
      input  rd_addr_NP,
      input  win_data,
      input  win_valid,
      input  win_row,
      input  win_col,
      input  frame_done
   );
endinterface

// File: rtl/conv_window_reader.sv
// conv_window_reader: walks KxK windows over a filled buffer
// in row-major order and hands each one to the conv core.
module conv_window_reader #(
   parameter int IMG_W        = 28,
   parameter int IMG_H        = 28,
   parameter int K            = 5,
   parameter int WIDTH        = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int OUT_PORT_NUM = K*K
) (
   input logic                 clk,
   input logic                 rst_n,
   conv_window_reader_if.master bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_COL =
      ADDR_WIDTH'(IMG_W - K);
   localparam logic [ADDR_WIDTH-1:0] LAST_ROW =
      ADDR_WIDTH'(IMG_H - K);
   localparam logic [ADDR_WIDTH-1:0] ONE =
      ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      FETCH,
      HOLD,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_WIDTH-1:0] row_q, row_d;
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   logic                  rd_en_q;

   logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [OUT_PORT_NUM*WIDTH-1:0]      data_q;

   // next state and window position; count is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      unique case (state_q)
         IDLE: begin
            if (bus.data_fill_cnt != 2'd0) begin
               state_d = ADDR;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ADDR:  state_d = FETCH;
         FETCH: state_d = HOLD;
         HOLD: begin
            if (bus.win_ready) begin
               if (col_q < LAST_COL) begin
                  col_d   = col_q + ONE;
                  state_d = ADDR;
               end else if (row_q < LAST_ROW) begin
                  col_d   = '0;
                  row_d   = row_q + ONE;
                  state_d = ADDR;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // tap addresses for the window about to be entered
   always_comb begin
      int tmp;
      tmp    = 0;
      addr_d = '0;
      for (int p = 0; p < OUT_PORT_NUM; p++) begin
         tmp = (int'(row_d) + p / K) * IMG_W
             + int'(col_d) + p % K;
         addr_d[p*ADDR_WIDTH +: ADDR_WIDTH] =
            ADDR_WIDTH'(tmp);
      end
   end

   // state and window position registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // rd_en stays high across all windows of a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q <= 1'b0;
      end else begin
         rd_en_q <= (state_d inside {ADDR, FETCH, HOLD});
      end
   end

   // addresses load on entry to ADDR and hold until the next one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else if (state_d == ADDR) begin
         addr_q <= addr_d;
      end
   end

   // buffer data lags the address by one cycle, caught in FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (state_q == FETCH) begin
         data_q <= bus.rd_data_NP;
      end
   end

   assign bus.rd_en      = rd_en_q;
   assign bus.rd_addr_NP = addr_q;
   assign bus.win_data   = data_q;
   assign bus.win_valid  = (state_q == HOLD);
   assign bus.win_row    = row_q;
   assign bus.win_col    = col_q;
   assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_conv_window_reader.sv
// tb_conv_window_reader: random-ready bench with a double
// buffer model and a row-major window reference.
module tb_conv_window_reader;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int KK   = 5;
   localparam int DW   = 16;
   localparam int AW   = 16;
   localparam int NP   = KK * KK;
   localparam int NC   = W - KK + 1;
   localparam int NWIN = NC * (H - KK + 1);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_window_reader_if #(
      .WIDTH(DW), .ADDR_WIDTH(AW), .OUT_PORT_NUM(NP)
   ) bus ();

   conv_window_reader #(
      .IMG_W(W), .IMG_H(H), .K(KK),
      .WIDTH(DW), .ADDR_WIDTH(AW), .OUT_PORT_NUM(NP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int vec  = 0;
   int errs = 0;

   // buffer model: word at address a holds a + salt;
   // each falling edge of rd_en releases one filled buffer
   logic [DW-1:0] salt = '0;
   int   base  = 0;
   int   rel   = 0;
   logic rd_en_d = 1'b0;

   always @(posedge clk) begin
      for (int p = 0; p < NP; p++)
         bus.rd_data_NP[p*DW +: DW] <=
            DW'(bus.rd_addr_NP[p*AW +: AW]) + salt;
      rd_en_d <= bus.rd_en;
      if (rd_en_d && !bus.rd_en) rel <= rel + 1;
   end

   assign bus.data_fill_cnt =
      (base > rel) ? 2'(base - rel) : 2'd0;

   function automatic logic [DW-1:0] mem(input int a);
      return DW'(a) + salt;
   endfunction

   task automatic collect(input int nfr, input int pct,
                          input int stall_idx,
                          input int stop_at);
      int   widx = 0;
      int   fd   = 0;
      int   cyc  = 0;
      int   gap  = -1;
      int   stall = 0;
      int   r, c, a;
      logic active  = 1'b0;
      logic stopped = 1'b0;
      while (fd < nfr && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (active) begin
            vec++;
            if (bus.rd_en !== 1'b1) begin
               errs++;
               $display("FAIL rd_en_held win=%0d got=%b want=1",
                        widx, bus.rd_en);
            end
         end
         if (bus.win_valid) begin
            if (widx == stop_at) begin
               bus.win_ready = 1'b0;
               stopped = 1'b1;
               break;
            end
            active = 1'b1;
            r = (widx % NWIN) / NC;
            c = widx % NC;
            vec++;
            if (bus.win_row !== AW'(r) ||
                bus.win_col !== AW'(c)) begin
               errs++;
               $display("FAIL win_pos got=(%0d,%0d) want=(%0d,%0d)",
                        bus.win_row, bus.win_col, r, c);
            end
            for (int p = 0; p < NP; p++) begin
               a = (r + p / KK) * W + c + p % KK;
               vec++;
               if (bus.win_data[p*DW +: DW] !== mem(a)) begin
                  errs++;
                  $display("FAIL win_data (%0d,%0d) p%0d got=%h want=%h",
                           r, c, p, bus.win_data[p*DW +: DW], mem(a));
               end
               vec++;
               if (bus.rd_addr_NP[p*AW +: AW] !== AW'(a)) begin
                  errs++;
                  $display("FAIL rd_addr (%0d,%0d) p%0d got=%0d want=%0d",
                           r, c, p, bus.rd_addr_NP[p*AW +: AW], a);
               end
            end
            if (widx == stall_idx && stall < 10) begin
               stall++;
               bus.win_ready = 1'b0;
            end else begin
               bus.win_ready = ($urandom_range(99) < pct);
            end
            if (bus.win_ready) begin
               widx++;
               if (widx % NWIN == 0) active = 1'b0;
            end
         end else begin
            bus.win_ready = 1'($urandom_range(1));
         end
         if (bus.frame_done) begin
            fd++;
            vec++;
            if (widx != fd * NWIN) begin
               errs++;
               $display("FAIL frame_windows got=%0d want=%0d",
                        widx, fd * NWIN);
            end
            vec++;
            if (bus.rd_en !== 1'b0 || bus.win_valid !== 1'b0) begin
               errs++;
               $display("FAIL done_outputs rd_en=%b valid=%b want=0,0",
                        bus.rd_en, bus.win_valid);
            end
            gap = 0;
         end
         if (gap >= 0) begin
            if (!bus.rd_en) gap++;
            else begin
               // low through DONE and the re-evaluating IDLE cycle
               vec++;
               if (gap != 2) begin
                  errs++;
                  $display("FAIL rd_en_gap got=%0d want=2", gap);
               end
               gap = -1;
            end
         end
      end
      bus.win_ready = 1'b0;
      if (!stopped) begin
         vec++;
         if (fd != nfr) begin
            errs++;
            $display("FAIL frame_timeout frames=%0d want=%0d",
                     fd, nfr);
         end
      end
      if (stall_idx >= 0) begin
         vec++;
         if (stall != 10) begin
            errs++;
            $display("FAIL stall_len got=%0d want=10", stall);
         end
      end
   endtask

   task automatic test_reset();
      base = 0;
      bus.win_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if (bus.rd_en !== 1'b0 || bus.win_valid !== 1'b0 ||
          bus.frame_done !== 1'b0) begin
         errs++;
         $display("FAIL reset_ctrl rd_en=%b valid=%b done=%b want=0",
                  bus.rd_en, bus.win_valid, bus.frame_done);
      end
      vec++;
      if (bus.win_data !== '0 || bus.rd_addr_NP !== '0) begin
         errs++;
         $display("FAIL reset_bus data/addr nonzero want=0");
      end
      vec++;
      if (bus.win_row !== '0 || bus.win_col !== '0) begin
         errs++;
         $display("FAIL reset_pos got=(%0d,%0d) want=(0,0)",
                  bus.win_row, bus.win_col);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_idle(input int n);
      base = rel;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.win_ready = 1'($urandom_range(1));
         vec++;
         if (bus.rd_en !== 1'b0 || bus.win_valid !== 1'b0 ||
             bus.frame_done !== 1'b0) begin
            errs++;
            $display("FAIL idle cyc=%0d rd_en=%b valid=%b done=%b want=0",
                     i, bus.rd_en, bus.win_valid, bus.frame_done);
         end
      end
      bus.win_ready = 1'b0;
   endtask

   task automatic test_single_frame();
      salt = '0;
      base = rel + 1;
      collect(1, 100, -1, -1);
      test_idle(20);
   endtask

   task automatic test_random_ready();
      salt = DW'($urandom);
      base = rel + 1;
      collect(1, 40, -1, -1);
      test_idle(5);
   endtask

   task automatic test_stall();
      salt = DW'($urandom);
      base = rel + 1;
      collect(1, 100, 1 * NC + 2, -1);
      test_idle(5);
   endtask

   task automatic test_mid_reset();
      salt = DW'($urandom);
      base = rel + 1;
      collect(1, 100, -1, 5);
      rst_n = 1'b0;
      #1;
      vec++;
      if (bus.rd_en !== 1'b0 || bus.win_valid !== 1'b0 ||
          bus.frame_done !== 1'b0) begin
         errs++;
         $display("FAIL midrst_ctrl rd_en=%b valid=%b done=%b want=0",
                  bus.rd_en, bus.win_valid, bus.frame_done);
      end
      vec++;
      if (bus.win_data !== '0 || bus.rd_addr_NP !== '0 ||
          bus.win_row !== '0 || bus.win_col !== '0) begin
         errs++;
         $display("FAIL midrst_bus outputs nonzero want=0");
      end
      repeat (3) @(negedge clk);
      base = rel;
      rst_n = 1'b1;
      @(negedge clk);
      base = rel + 1;
      collect(1, 100, -1, -1);
      test_idle(5);
   endtask

   task automatic test_back_to_back();
      salt = DW'($urandom);
      base = rel + 2;
      collect(2, 70, -1, -1);
      test_idle(20);
   endtask

   initial begin
      bus.win_ready = 1'b0;
      test_reset();
      test_idle(50);
      test_single_frame();
      test_random_ready();
      test_stall();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==",
               vec, errs);
      $finish;
   end

endmodule
